alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
- Sequences the shared 32-bit ALU between two requesters: requester 0 is the pipeline EX stage, requester 1 is the branch/address unit.
- Round-robin arbitration with valid/ready handshakes on both the request and response sides.
- One operation in flight at a time.
- Add and logic ops take one execute cycle; multiply takes a configurable number of cycles.

Parameters:
- MUL_CYCLES, 4: execute cycles for op 1001 (legal range 1..15).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- req0_valid  in  1  requester 0 presents an op
- req0_ready  out  1  requester 0 op accepted this cycle when valid&ready
- req0_a  in  32  operand a, requester 0
- req0_b  in  32  operand b, requester 0
- req0_op  in  4  op code, requester 0
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as above, for requester 1
- rsp0_valid  out  1  response for requester 0 on the shared result bus
- rsp1_valid  out  1  response for requester 1
- rsp0_ready  in  1  requester 0 consumes the response
- rsp1_ready  in  1  requester 1 consumes the response
- rsp_result  out  32  registered result
- rsp_zero  out  1  registered zero flag
- rsp_err  out  1  illegal op code flag
- busy  out  1  high whenever state != IDLE

Behaviour:
- Op semantics. All ops are unsigned, mod 2^32.
  - 0000: a+b
  - 0001: a-b
  - 1001: low 32 bits of a*b
  - 0010: a|b
  - 0011: a&b
  - 0100: a^b
  - 0101: b>>a
  - 0110: b<<a (for either shift, a >= 32 gives 0)
  - 0111: a>b ? 1 : 0
  - 1000: a<b ? 1 : 0
  - 1111: ~(a|b)
  - 1010..1110 are illegal: rsp_err=1, rsp_result=0, rsp_zero=0.
- rsp_zero = 1 only for op 0001 with a==b. It is 0 for every other op.
- States:
  - IDLE -> EXEC on accept.
  - EXEC -> RESP when the cycle counter expires.
  - RESP -> IDLE on the rsp handshake.
- Arbitration (IDLE only):
  - req_ready is combinational from the valids and the last_grant register.
  - One valid only: that requester is granted.
  - Both valid: the requester != last_grant wins. last_grant updates on accept.
  - Reset sets last_grant=1, so requester 0 wins the first contest.
  - req0_ready and req1_ready are never both 1. Both are 0 outside IDLE.
- Accept edge: a, b, op and owner are captured into registers. Requester inputs are ignored until the next IDLE.
- EXEC:
  - Counter loads MUL_CYCLES-1 for op 1001, otherwise 0.
  - State stays in EXEC until the counter is 0.
  - On that edge: result, zero and err are registered, and the state moves to RESP.
  - Latency, non-mul: accept at edge T, rsp valid from edge T+1.
  - Latency, mul: rsp valid from edge T+MUL_CYCLES.
- RESP:
  - rsp<owner>_valid=1 and the other rsp valid is 0.
  - rsp_result, rsp_zero and rsp_err are held stable until rsp<owner>_ready=1.
  - The handshake edge returns to IDLE. No accept happens on the same edge.
  - Minimum initiation interval is 3 cycles.
- rsp_ready of the non-owner is ignored.
- Requester valid may drop before acceptance with no side effects.
- Reset, asynchronous at any point including mid-EXEC or RESP:
  - state=IDLE, counter=0, last_grant=1.
  - All ready and valid outputs 0; rsp_result=0, rsp_zero=0, rsp_err=0, busy=0.
  - The in-flight op is discarded with no response.
- rsp_* outputs keep their last value in IDLE and EXEC. Consumers qualify them with valid.

Test Plan:
- Single add: req0 a=5, b=7, op=0000 accepted at edge T with rsp0_ready=1. Expect rsp0_valid at T+1, result=12, zero=0, err=0, then IDLE at T+2.
- Sub zero: req1 a=b=0x1234, op=0001. Expect result=0, zero=1, rsp1_valid only.
- Round-robin: both valid continuously after reset with ops 0010 and 0011. Expect grants 0,1,0,1 and req ready one-hot.
- Multiply with MUL_CYCLES=4: a=0x10000, b=0x10000, op=1001. Expect result=0, rsp valid exactly 4 edges after accept, and busy high for the whole operation.
- Backpressure and illegal op: op=1100 with rsp0_ready held 0 for 5 cycles. Expect rsp0_valid stuck at 1, err=1, result=0 stable, req1_ready=0 meanwhile.
- Reset mid-mul: rst pulsed 2 cycles after accept. Expect all outputs 0 immediately and no response. The next contest is won by requester 0.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one 32-bit ALU between two requesters
// (0 = pipeline EX stage, 1 = branch/address unit).
// Round-robin arbitration in IDLE, one operation in flight, registered response.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   reqN_valid/ready/a/b/op      request channel of requester N (N = 0, 1)
//   rspN_valid/ready             response handshake of requester N
//   rsp_result/zero/err          shared registered response bus
//   busy                         high whenever the controller is not IDLE
module alu_share_ctrl #(
    parameter int unsigned MUL_CYCLES = 4  // execute cycles for multiply, 1..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    input  logic        rsp0_ready,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    localparam logic [3:0] OpMul   = 4'b1001;
    localparam logic [3:0] MulLoad = 4'(MUL_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] a_q, b_q;
    logic [3:0]  op_q;
    logic [3:0]  cnt_q;
    logic        owner_q;
    logic        last_grant_q;
    logic [31:0] result_q;
    logic        zero_q, err_q;

    logic        grant0, grant1, accept;
    logic        exec_done, rsp_fire;
    logic [31:0] alu_result;
    logic        alu_zero, alu_err;
    logic [3:0]  sel_op;

    // Readies are forced low during reset so nothing looks accepted while rst is high.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == StIdle && !rst) begin
            if (req0_valid && req1_valid) begin
                if (last_grant_q) grant0 = 1'b1;
                else              grant1 = 1'b1;
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 | grant1;
    assign sel_op     = grant1 ? req1_op : req0_op;

    assign exec_done = (state_q == StExec) && (cnt_q == 4'd0);
    // Non-owner rsp_ready is deliberately ignored.
    assign rsp_fire  = (state_q == StResp) && (owner_q ? rsp1_ready : rsp0_ready);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept)    state_d = StExec;
            StExec:  if (exec_done) state_d = StResp;
            StResp:  if (rsp_fire)  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        alu_result = 32'd0;
        alu_zero   = 1'b0;
        alu_err    = 1'b0;
        case (op_q)
            4'b0000: alu_result = a_q + b_q;
            4'b0001: begin
                alu_result = a_q - b_q;
                alu_zero   = (a_q == b_q);
            end
            4'b1001: alu_result = a_q * b_q;
            4'b0010: alu_result = a_q | b_q;
            4'b0011: alu_result = a_q & b_q;
            4'b0100: alu_result = a_q ^ b_q;
            4'b0101: alu_result = (a_q[31:5] != 27'd0) ? 32'd0 : (b_q >> a_q[4:0]);
            4'b0110: alu_result = (a_q[31:5] != 27'd0) ? 32'd0 : (b_q << a_q[4:0]);
            4'b0111: alu_result = {31'd0, a_q > b_q};
            4'b1000: alu_result = {31'd0, a_q < b_q};
            4'b1111: alu_result = ~(a_q | b_q);
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            op_q         <= 4'd0;
            cnt_q        <= 4'd0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            result_q     <= 32'd0;
            zero_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q          <= grant1 ? req1_a : req0_a;
                b_q          <= grant1 ? req1_b : req0_b;
                op_q         <= sel_op;
                owner_q      <= grant1;
                last_grant_q <= grant1;
                cnt_q        <= (sel_op == OpMul) ? MulLoad : 4'd0;
            end else if (state_q == StExec) begin
                if (cnt_q != 4'd0) begin
                    cnt_q <= cnt_q - 4'd1;
                end else begin
                    result_q <= alu_result;
                    zero_q   <= alu_zero;
                    err_q    <= alu_err;
                end
            end
        end
    end

    assign rsp0_valid = (state_q == StResp) && !owner_q;
    assign rsp1_valid = (state_q == StResp) && owner_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed plus randomized checks of alu_share_ctrl against a
// transaction-level reference (ALU function, round-robin winner, latency).
module tb_alu_share_ctrl;

    localparam int unsigned MulCycles = 4;

    logic        clk, rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_err, busy;

    int n_tests = 0;
    int n_fail  = 0;
    int last_grant = 1;  // reference arbitration history

    alu_share_ctrl #(.MUL_CYCLES(MulCycles)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference ALU: returns {err, zero, result}.
    function automatic logic [33:0] ref_alu(input logic [31:0] a, b, input logic [3:0] op);
        logic [31:0] r;
        logic [63:0] p;
        r = 32'd0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd9:  begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
            4'd2:  r = a | b;
            4'd3:  r = a & b;
            4'd4:  r = a ^ b;
            4'd5:  r = (a >= 32) ? 32'd0 : b >> a;
            4'd6:  r = (a >= 32) ? 32'd0 : b << a;
            4'd7:  r = (a > b) ? 32'd1 : 32'd0;
            4'd8:  r = (a < b) ? 32'd1 : 32'd0;
            4'd15: r = ~(a | b);
            default: return {2'b10, 32'd0};
        endcase
        return {1'b0, (op == 4'd1) && (a == b), r};
    endfunction

    task automatic finish_now();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_op(input logic v0, v1, input logic [31:0] a0, b0, a1, b1,
                          input logic [3:0] op0, op1, input int hold);
        int win, lat, exp_lat;
        logic [31:0] ea, eb;
        logic [3:0]  eop;
        logic [33:0] exp;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        #1;
        if (v0 && v1) win = (last_grant == 0) ? 1 : 0;
        else          win = v0 ? 0 : 1;
        check_eq("req0_ready", req0_ready, win == 0);
        check_eq("req1_ready", req1_ready, win == 1);
        ea  = win ? a1 : a0;
        eb  = win ? b1 : b0;
        eop = win ? op1 : op0;
        exp = ref_alu(ea, eb, eop);
        exp_lat = (eop == 4'd9) ? MulCycles : 1;
        @(posedge clk);
        last_grant = win;
        @(negedge clk);
        // Scramble requester inputs: they must be ignored until IDLE again.
        req0_valid = 1'($urandom_range(0, 1)); req0_a = $urandom; req0_op = 4'($urandom);
        req1_valid = 1'($urandom_range(0, 1)); req1_b = $urandom; req1_op = 4'($urandom);
        lat = 0;
        while (!(win ? rsp1_valid : rsp0_valid)) begin
            if (busy !== 1'b1 || req0_ready || req1_ready || rsp0_valid || rsp1_valid)
                check_eq("exec_outputs", {busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid},
                         32'b10000);
            lat++;
            if (lat > 40) begin
                check_eq("rsp_timeout", 32'd1, 32'd0);
                finish_now();
            end
            @(negedge clk);
        end
        check_eq("latency", lat, exp_lat);
        check_eq("rsp_result", rsp_result, exp[31:0]);
        check_eq("rsp_zero", rsp_zero, exp[32]);
        check_eq("rsp_err", rsp_err, exp[33]);
        check_eq("rsp_other_valid", win ? rsp0_valid : rsp1_valid, 1'b0);
        check_eq("resp_ready_low", {req0_ready, req1_ready}, 2'b00);
        for (int h = 0; h < hold; h++) begin
            rsp0_ready = (win == 1);
            rsp1_ready = (win == 0);
            @(negedge clk);
            check_eq("hold_valid", win ? rsp1_valid : rsp0_valid, 1'b1);
            check_eq("hold_result", {rsp_err, rsp_zero, rsp_result}, exp);
            check_eq("hold_ready", {req0_ready, req1_ready, busy}, 3'b001);
        end
        rsp0_ready = (win == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        rsp1_ready = (win == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check_eq("back_to_idle", {busy, rsp0_valid, rsp1_valid}, 3'b000);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    initial begin
        logic [3:0]  op0, op1;
        logic [31:0] a0, a1;
        logic        v0, v1;
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #12;
        check_eq("reset_outputs",
                 {busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero, rsp_err},
                 7'd0);
        check_eq("reset_result", rsp_result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        run_op(1, 0, 5, 7, 0, 0, 4'b0000, 4'b0000, 0);
        run_op(0, 1, 0, 0, 32'h1234, 32'h1234, 4'b0000, 4'b0001, 0);
        last_grant = 1;
        for (int i = 0; i < 4; i++)
            run_op(1, 1, $urandom, $urandom, $urandom, $urandom, 4'b0010, 4'b0011, 0);
        run_op(1, 0, 32'h10000, 32'h10000, 0, 0, 4'b1001, 4'b0000, 1);
        run_op(1, 0, $urandom, $urandom, 0, 0, 4'b1100, 4'b0000, 5);

        // A valid that drops before any edge leaves no trace.
        req1_valid = 1'b1;
        #2 req1_valid = 1'b0;
        @(negedge clk);
        check_eq("dropped_valid", busy, 1'b0);

        // Reset in the middle of a multiply.
        req0_valid = 1'b1; req0_a = 3; req0_b = 9; req0_op = 4'b1001;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("midrst_outputs",
                 {busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero, rsp_err},
                 7'd0);
        check_eq("midrst_result", rsp_result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req1_valid = 1'b0;
        last_grant = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid || busy)
                check_eq("midrst_no_rsp", {busy, rsp0_valid, rsp1_valid}, 3'd0);
        end
        check_eq("midrst_quiet", busy, 1'b0);
        run_op(1, 1, 1, 2, 3, 4, 4'b0000, 4'b0000, 0);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            op0 = 4'($urandom);
            op1 = 4'($urandom);
            a0 = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
            a1 = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
            if ($urandom_range(0, 7) == 0) a1 = 32'hCAFE0000;
            run_op(v0, v1, a0, $urandom, a1, ($urandom_range(0, 7) == 0) ? a1 : $urandom,
                   op0, op1, $urandom_range(0, 3));
        end
        finish_now();
    end

endmodule
